// File: rtl/ram_pkg.sv
// Shared types and helpers for the simple-dual-port RAM with init sweep.
package ram_pkg;

  typedef enum logic {INIT, READY} state_t;

  // Widest word the merge helper handles; callers size-cast in and out.
  localparam int MERGE_W = 256;

  function automatic logic [MERGE_W-1:0] be_merge(
    input logic [MERGE_W-1:0]   old_v,
    input logic [MERGE_W-1:0]   new_v,
    input logic [MERGE_W/8-1:0] be
  );
    logic [MERGE_W-1:0] r;
    r = old_v;
    for (int k = 0; k < MERGE_W/8; k++) begin
      if (be[k]) r[8*k +: 8] = new_v[8*k +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/ram_sdp_core.sv
// Bare storage array: byte-enabled synchronous write, combinational read, no reset.
module ram_sdp_core #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int BW = WIDTH / 8
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [BW-1:0]    wbe_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int k = 0; k < BW; k++) begin
        if (wbe_i[k]) mem_q[waddr_i][8*k +: 8] <= wdata_i[8*k +: 8];
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ram_sdp_init.sv
// Simple-dual-port RAM wrapper: self-clearing init sweep, range checks,
// same-address bypass and a 1- or 2-cycle registered read path.
module ram_sdp_init
  import ram_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 8,
  parameter int RD_LAT = 1,
  parameter int BYPASS = 1,
  localparam int AW = $clog2(DEPTH),
  localparam int BW = WIDTH / 8
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic             init_done,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [BW-1:0]    wr_be,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid
);

  state_t           state_q;
  logic [AW-1:0]    ptr_q;
  logic             init_done_q;
  logic             core_we;
  logic [AW-1:0]    core_waddr;
  logic [BW-1:0]    core_wbe;
  logic [WIDTH-1:0] core_wdata;
  logic [WIDTH-1:0] core_rdata;
  logic             wr_ok;
  logic             rd_in_range;
  logic             bypass_hit;
  logic             vld_p0;
  logic [WIDTH-1:0] data_p0;
  logic [WIDTH-1:0] rd_data_q;
  logic             rd_valid_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= INIT;
      ptr_q       <= '0;
      init_done_q <= 1'b0;
    end else if (state_q == INIT) begin
      if (ptr_q == AW'(DEPTH - 1)) begin
        state_q     <= READY;
        init_done_q <= 1'b1;
      end else begin
        ptr_q <= ptr_q + 1'b1;
      end
    end
  end

  // Sweep owns the write port until READY; user writes beyond DEPTH are dropped.
  assign wr_ok      = init_done_q && wr_en && (int'(wr_addr) < DEPTH);
  assign core_we    = (state_q == INIT) || wr_ok;
  assign core_waddr = (state_q == INIT) ? ptr_q : wr_addr;
  assign core_wbe   = (state_q == INIT) ? '1 : wr_be;
  assign core_wdata = (state_q == INIT) ? '0 : wr_data;

  ram_sdp_core #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_core (
    .clk     (clk),
    .we_i    (core_we),
    .waddr_i (core_waddr),
    .wbe_i   (core_wbe),
    .wdata_i (core_wdata),
    .raddr_i (rd_addr),
    .rdata_o (core_rdata)
  );

  // Stage p0: address decode, range check and same-address bypass merge.
  assign vld_p0      = init_done_q && rd_en;
  assign rd_in_range = int'(rd_addr) < DEPTH;
  assign bypass_hit  = (BYPASS != 0) && wr_ok && (wr_addr == rd_addr);

  always_comb begin
    data_p0 = '0;
    if (rd_in_range) begin
      if (bypass_hit)
        data_p0 = WIDTH'(be_merge(MERGE_W'(core_rdata), MERGE_W'(wr_data),
                                  (MERGE_W/8)'(wr_be)));
      else
        data_p0 = core_rdata;
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic             vld_p1;
    logic [WIDTH-1:0] data_p1;

    // Stage p1 then output register.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        vld_p1     <= 1'b0;
        data_p1    <= '0;
        rd_valid_q <= 1'b0;
        rd_data_q  <= '0;
      end else begin
        vld_p1     <= vld_p0;
        if (vld_p0) data_p1 <= data_p0;
        rd_valid_q <= vld_p1;
        if (vld_p1) rd_data_q <= data_p1;
      end
    end
  end else begin : g_lat1
    // Stage p0 straight into the output register.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        rd_valid_q <= 1'b0;
        rd_data_q  <= '0;
      end else begin
        rd_valid_q <= vld_p0;
        if (vld_p0) rd_data_q <= data_p0;
      end
    end
  end

  assign init_done = init_done_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;

endmodule
